// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one 16-bit fetch at a time to instruction memory
// and buffers responses in a small in-order queue; redirects flush and refetch.
module fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [1:0]  dbg_state      // 0 = IDLE, 1 = BUSY, 2 = DROP
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   req_pc_q, req_pc_d;
    logic [15:0]   data_mem_q [DEPTH];
    logic [15:0]   addr_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] remain;
    logic [15:0]   out_data_q, out_data_d;
    logic [15:0]   out_pc_q, out_pc_d;
    logic          grant;
    logic          push;
    logic          pop;

    // Handshakes: a fetch transfers when imem_req && imem_gnt; an instruction
    // transfers when instr_valid && instr_ready. imem_addr never moves while a
    // request is waiting, because pc_q only changes on grant or redirect, and a
    // redirect withdraws the request in the same cycle.
    always_comb begin
        imem_req = rst_n && (state_q == IDLE) && !redirect && (count_q < FULL);
        grant    = imem_req && imem_gnt;
        push     = (state_q == BUSY) && imem_rvalid && !redirect;
        pop      = (count_q != '0) && instr_ready && !redirect;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = BUSY;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 16'd2;
                end
            end
            BUSY: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Odd targets are forced even; fetches are always halfword aligned.
        if (redirect) begin
            pc_d = redirect_pc & 16'hFFFE;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        remain   = count_q - CW'(pop);
        out_data_d = out_data_q;
        out_pc_d   = out_pc_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (remain == '0) begin
            // Queue drains this cycle; only a bypassed push can become the head.
            if (push) begin
                out_data_d = imem_rdata;
                out_pc_d   = req_pc_q;
            end
        end else begin
            out_data_d = data_mem_q[rd_ptr_d];
            out_pc_d   = addr_mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= 16'h0000;
            out_pc_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_pc_q   <= out_pc_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            addr_mem_q[wr_ptr_q] <= req_pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_out   = out_data_q;
    assign instr_pc    = out_pc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a transaction-level model of the expected in-order instruction stream.
module tb_fetch_queue;

    localparam logic [15:0] RST_PC = 16'hFFFC;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  dbg_state;

    fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: expected queue contents (pcs), memory pipeline, fetch pointer.
    logic [15:0] exp_q[$];
    logic [15:0] pop_log[$];
    logic [15:0] grant_log[$];
    logic [15:0] exp_fetch_pc;
    logic [15:0] hold_pc, hold_data;
    logic [15:0] mem_addr_p;
    bit          mem_pending, mem_stale;
    int          mem_cnt;

    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit ready_ovr_en = 1'b1, ready_ovr = 1'b1, ghost_rv = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_pending  = 1'b0;
        mem_stale    = 1'b0;
        mem_cnt      = 0;
        exp_fetch_pc = RST_PC;
        hold_pc      = 16'h0000;
        hold_data    = 16'h0000;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance model.
    task automatic tick(input bit redir, input logic [15:0] rpc);
        bit pred_req, rv, resp, g, pop, kept;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = ready_ovr_en ? ready_ovr : ($urandom_range(99) < rdy_pct);
        resp        = mem_pending && (mem_cnt == 0);
        rv          = resp || ghost_rv;
        imem_rvalid = rv;
        imem_rdata  = resp ? mem_word(mem_addr_p) : 16'($urandom);
        #1;
        pred_req = rst_n && !redir && !mem_pending && (exp_q.size() < DEPTH);
        chk("req", imem_req, 16'(pred_req));
        if (pred_req) chk("addr", imem_addr, exp_fetch_pc);
        chk("state", dbg_state, !mem_pending ? 16'd0 : (mem_stale ? 16'd2 : 16'd1));
        chk("valid", instr_valid, 16'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("pc", instr_pc, exp_q[0]);
            chk("out", instr_out, mem_word(exp_q[0]));
            hold_pc   = exp_q[0];
            hold_data = mem_word(exp_q[0]);
        end else begin
            chk("hold_pc", instr_pc, hold_pc);
            chk("hold_out", instr_out, hold_data);
        end
        imem_gnt = pred_req ? ($urandom_range(99) < gnt_pct) : 1'($urandom);
        g    = pred_req && imem_gnt;
        pop  = (exp_q.size() != 0) && instr_ready && !redir;
        kept = resp && !mem_stale && !redir;
        if (pop) pop_log.push_back(exp_q.pop_front());
        if (kept) begin
            chk("no_overflow", 16'(exp_q.size() < DEPTH), 16'd1);
            exp_q.push_back(mem_addr_p);
        end
        if (resp) begin
            mem_pending = 1'b0;
            mem_stale   = 1'b0;
        end else if (mem_pending) begin
            if (redir) mem_stale = 1'b1;
            mem_cnt--;
        end
        if (redir) begin
            exp_q.delete();
            exp_fetch_pc = rpc & 16'hFFFE;
        end
        if (g) begin
            mem_pending = 1'b1;
            mem_stale   = 1'b0;
            mem_addr_p  = exp_fetch_pc;
            mem_cnt     = $urandom_range(lat_max, lat_min) - 1;
            grant_log.push_back(imem_addr);
            exp_fetch_pc = exp_fetch_pc + 16'd2;
        end
        if (!rst_n) model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", imem_req, 16'd0);
        chk("rst_valid", instr_valid, 16'd0);
        chk("rst_out", instr_out, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_addr", imem_addr, RST_PC);
        model_reset();
        rst_n = 1'b1;

        // Zero-wait memory from reset: addresses wrap FFFC, FFFE, 0000, 0002.
        repeat (20) tick(1'b0, 16'h0);
        chk("wrap_n", 16'(grant_log.size() >= 4), 16'd1);
        chk("wrap0", grant_log[0], 16'hFFFC);
        chk("wrap1", grant_log[1], 16'hFFFE);
        chk("wrap2", grant_log[2], 16'h0000);
        chk("wrap3", grant_log[3], 16'h0002);

        // Redirect to 0, expect instr_pc stream 0,2,4,6.
        tick(1'b1, 16'h0000);
        pop_log.delete();
        repeat (20) tick(1'b0, 16'h0);
        chk("seq_n", 16'(pop_log.size() >= 4), 16'd1);
        chk("seq0", pop_log[0], 16'h0000);
        chk("seq1", pop_log[1], 16'h0002);
        chk("seq2", pop_log[2], 16'h0004);
        chk("seq3", pop_log[3], 16'h0006);

        // Backpressure fills the queue; request must drop.
        ready_ovr = 1'b0; lat_max = 3;
        repeat (12) tick(1'b0, 16'h0);
        #1;
        chk("full_valid", instr_valid, 16'd1);
        chk("full_req", imem_req, 16'd0);
        ready_ovr = 1'b1;
        repeat (15) tick(1'b0, 16'h0);

        // Redirect while BUSY; stale response returns 3 cycles later.
        lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_pending && !mem_stale && mem_cnt == 3) found = 1'b1;
            else tick(1'b0, 16'h0);
        end
        chk("busy_found", 16'(found), 16'd1);
        pop_log.delete();
        tick(1'b1, 16'h0040);
        lat_min = 1; lat_max = 1;
        repeat (20) tick(1'b0, 16'h0);
        chk("redir_first", pop_log[0], 16'h0040);

        // Redirect coincident with rvalid and a pop.
        lat_min = 3; lat_max = 3; ready_ovr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (exp_q.size() > 0 && mem_pending && !mem_stale && mem_cnt == 0) found = 1'b1;
            else tick(1'b0, 16'h0);
        end
        chk("coin_found", 16'(found), 16'd1);
        ready_ovr = 1'b1;
        tick(1'b1, 16'h0080);
        redirect = 1'b0; #1;
        chk("coin_valid", instr_valid, 16'd0);
        chk("coin_req", imem_req, 16'd1);
        chk("coin_addr", imem_addr, 16'h0080);
        repeat (10) tick(1'b0, 16'h0);

        // Odd redirect target is forced even.
        tick(1'b1, 16'h0123);
        redirect = 1'b0; #1;
        chk("odd_addr", imem_addr, 16'h0122);
        repeat (10) tick(1'b0, 16'h0);

        // Reset while BUSY, then a late response while IDLE.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_pending && !mem_stale && mem_cnt > 0) found = 1'b1;
            else tick(1'b0, 16'h0);
        end
        chk("rbusy_found", 16'(found), 16'd1);
        rst_n = 1'b0;
        tick(1'b0, 16'h0);
        rst_n = 1'b1; gnt_pct = 0; ghost_rv = 1'b1;
        repeat (2) tick(1'b0, 16'h0);
        ghost_rv = 1'b0; #1;
        chk("late_valid", instr_valid, 16'd0);
        chk("late_addr", imem_addr, RST_PC);
        grant_log.delete();
        gnt_pct = 100;
        repeat (10) tick(1'b0, 16'h0);
        chk("restart", grant_log[0], RST_PC);

        // Random traffic.
        ready_ovr_en = 1'b0; rdy_pct = 70; gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(99) < 3, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: RESET_PC, 16'd0, fetch address loaded at reset.
REQ-002 Parameter: DEPTH, 2, instruction queue entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  16  fetch address; held stable while imem_req=1 and imem_gnt=0.
REQ-007 imem_gnt  input  1  memory accepts request; handshake completes on a cycle with imem_req=1 and imem_gnt=1.
REQ-008 imem_rvalid  input  1  response valid, 1 cycle; arrives at least 1 cycle after its grant.
REQ-009 imem_rdata  input  16  instruction word, valid with imem_rvalid.
REQ-010 instr_valid  output  1  queue head holds a valid instruction.
REQ-011 instr_out  output  16  head instruction, feeds datapath opcode/register fields.
REQ-012 instr_pc  output  16  address of head instruction.
REQ-013 instr_ready  input  1  consumer accepts head; pop on instr_valid=1 and instr_ready=1.
REQ-014 redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  input  16  new fetch address, sampled when redirect=1.

Function
REQ-016 Fetch PC advances by 16'd2 per granted request; 16-bit wrap, 16'hFFFE+2=16'h0000.
REQ-017 At most one request outstanding: granted, response not yet received.
REQ-018 FSM states: IDLE (none outstanding), BUSY (one outstanding, response kept), DROP (one outstanding, response discarded).
REQ-019 imem_req=1 only in IDLE, with redirect=0, and with occupancy plus pending pushes < DEPTH.
REQ-020 IDLE -> BUSY on grant; BUSY -> IDLE on imem_rvalid; DROP -> IDLE on imem_rvalid.
REQ-021 In BUSY, imem_rvalid pushes {imem_rdata, address of that request} into the queue tail.
REQ-022 In DROP, imem_rvalid is consumed and nothing is pushed.
REQ-023 Push and pop in the same cycle are both performed; occupancy unchanged.
REQ-024 Queue never overflows; push when full is impossible per REQ-019. Bench asserts no push when full.
REQ-025 Output data is registered; a response is visible on instr_out no earlier than the cycle after imem_rvalid.
REQ-026 Fetch-to-valid latency from an empty queue is grant cycle + memory latency + 1 cycle.
REQ-027 Redirect flushes the queue the next cycle: instr_valid=0, fetch PC=redirect_pc.
REQ-028 Redirect in BUSY, or in the same cycle as a grant, goes to DROP.
REQ-029 Redirect in the same cycle as imem_rvalid drops that response.
REQ-030 Redirect overrides a same-cycle pop and push.
REQ-031 Redirect while imem_req=1 and imem_gnt=0 withdraws the request; the next request uses redirect_pc.
REQ-032 A redirect_pc with bit 0 set is forced even: bit 0 is cleared.
REQ-033 instr_valid=0 implies instr_out and instr_pc hold their last value; no X propagation.

Reset
REQ-034 When rst_n=0 at a rising edge: FSM=IDLE, queue empty, fetch PC=RESET_PC.
REQ-035 Reset outputs: instr_valid=0, imem_req=0, instr_out=16'h0000, instr_pc=16'h0000, imem_addr=RESET_PC.
REQ-036 Reset mid-transaction abandons any outstanding response; an imem_rvalid in the first 4 cycles after reset release while IDLE is ignored.
REQ-037 imem_req may assert the first cycle after reset release.

Verification
REQ-038 Zero-wait memory (grant same cycle, rvalid next), instr_ready=1 -> instr_pc sequence 0,2,4,6; instr_out matches memory image.
REQ-039 instr_ready=0 for 10 cycles -> exactly DEPTH entries held; imem_req=0 when full; no loss or duplication after release.
REQ-040 Redirect to 16'h0040 while BUSY; stale response returns 3 cycles later -> stale word dropped; first valid instr_pc=16'h0040.
REQ-041 Redirect coincident with imem_rvalid and a pop -> queue empty next cycle; next imem_addr=redirect_pc.
REQ-042 RESET_PC=16'hFFFC -> fetch addresses FFFC, FFFE, 0000, 0002.
REQ-043 rst_n=0 while BUSY, then a late imem_rvalid -> no push; instr_valid=0; restart from RESET_PC.
